// File: rtl/ara_exit_pkg.sv
// Shared register indices, response codes, channel states and helpers for the
// Ara exit controller.
package ara_exit_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    REG_EXIT    = 2'd0,
    REG_CYCLE   = 2'd1,
    REG_WDOG    = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_idx_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [DATA_W-1:0] WDOG_CODE_DEFAULT = 64'hFFFF;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rd_rsp_t;

  // Byte-strobed update of a register value.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_q,
                                                   input logic [DATA_W-1:0] new_d,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_q;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_d[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ara_exit_wdog.sv
// Free-running cycle counter that freezes on exit, plus the watchdog compare.
module ara_exit_wdog
  import ara_exit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_done,
  input  logic [DATA_W-1:0] i_wdog,
  output logic [DATA_W-1:0] o_cycle,
  output logic              o_trip_c
);

  logic [DATA_W-1:0] r_cycle;

  // The tripping cycle already counts as the exit, so the counter holds there.
  assign o_trip_c = (i_wdog != '0) && !i_done && (r_cycle == i_wdog);
  assign o_cycle  = r_cycle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycle <= '0;
    end else if (!i_done && !o_trip_c) begin
      r_cycle <= r_cycle + DATA_W'(1);
    end
  end

endmodule

// File: rtl/ara_exit_ctrl.sv
// AXI4-Lite responder terminating the tohost exit protocol, with a cycle
// counter, a watchdog that forces a failing exit, and a scratch register.
module ara_exit_ctrl
  import ara_exit_pkg::*;
#(
  parameter int unsigned       AddrWidth = 64,
  parameter logic [DATA_W-1:0] WdogCode  = WDOG_CODE_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [DATA_W-1:0]    w_data_i,
  input  logic [STRB_W-1:0]    w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [DATA_W-1:0]    r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [DATA_W-1:0]    exit_o
);

  wr_state_e         r_wstate, w_wstate_d;
  rd_state_e         r_rstate, w_rstate_d;
  logic              w_wr_hs, w_rd_hs;
  logic [DATA_W-1:0] r_exit, r_wdog, r_scratch, w_cycle;
  logic              w_trip;
  logic [1:0]        r_bresp;
  rd_rsp_t           r_rsp, w_rsp_d;
  reg_idx_e          w_wsel, w_rsel;
  logic              w_werr, w_wr_exit, w_wr_wdog, w_wr_scratch;
  logic              w_unused;

  assign w_unused = ^{aw_addr_i[AddrWidth-1:5], ar_addr_i[AddrWidth-1:5]};

  ara_exit_wdog u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_done   (r_exit[0]),
    .i_wdog   (r_wdog),
    .o_cycle  (w_cycle),
    .o_trip_c (w_trip)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_d;
      r_rstate <= w_rstate_d;
    end
  end

  // Write channel: AW and W are only ever taken together.
  always_comb begin
    w_wstate_d = r_wstate;
    w_wr_hs    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (aw_valid_i && w_valid_i) begin
          w_wr_hs    = 1'b1;
          w_wstate_d = W_RESP;
        end
      end
      W_RESP:  if (b_ready_i) w_wstate_d = W_IDLE;
      default: w_wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_d = r_rstate;
    w_rd_hs    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (ar_valid_i) begin
          w_rd_hs    = 1'b1;
          w_rstate_d = R_RESP;
        end
      end
      R_RESP:  if (r_ready_i) w_rstate_d = R_IDLE;
      default: w_rstate_d = R_IDLE;
    endcase
  end

  // Ready is gated by reset so nothing handshakes while the block is held.
  assign aw_ready_o = w_wr_hs && rst_ni;
  assign w_ready_o  = w_wr_hs && rst_ni;
  assign ar_ready_o = (r_rstate == R_IDLE) && rst_ni;
  assign b_valid_o  = (r_wstate == W_RESP);
  assign b_resp_o   = r_bresp;
  assign r_valid_o  = (r_rstate == R_RESP);
  assign r_data_o   = r_rsp.data;
  assign r_resp_o   = r_rsp.resp;
  assign exit_o     = r_exit;

  always_comb begin
    w_wsel       = reg_idx_e'(aw_addr_i[4:3]);
    w_werr       = (aw_addr_i[2:0] != 3'd0) || (w_wsel == REG_CYCLE);
    w_wr_exit    = w_wr_hs && !w_werr && (w_wsel == REG_EXIT) && !r_exit[0];
    w_wr_wdog    = w_wr_hs && !w_werr && (w_wsel == REG_WDOG);
    w_wr_scratch = w_wr_hs && !w_werr && (w_wsel == REG_SCRATCH);
  end

  // Read data is a snapshot of the pre-edge register values.
  always_comb begin
    w_rsel       = reg_idx_e'(ar_addr_i[4:3]);
    w_rsp_d.data = '0;
    w_rsp_d.resp = RESP_OKAY;
    if (ar_addr_i[2:0] != 3'd0) begin
      w_rsp_d.resp = RESP_SLVERR;
    end else begin
      case (w_rsel)
        REG_EXIT:    w_rsp_d.data = r_exit;
        REG_CYCLE:   w_rsp_d.data = w_cycle;
        REG_WDOG:    w_rsp_d.data = r_wdog;
        REG_SCRATCH: w_rsp_d.data = r_scratch;
        default:     w_rsp_d.data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exit    <= '0;
      r_wdog    <= '0;
      r_scratch <= '0;
      r_bresp   <= RESP_OKAY;
      r_rsp     <= '0;
    end else begin
      if (w_wr_exit) begin
        r_exit <= strb_merge(r_exit, w_data_i, w_strb_i);
      end else if (w_trip) begin
        r_exit <= {WdogCode[DATA_W-2:0], 1'b1};
      end
      if (w_wr_wdog)    r_wdog    <= strb_merge(r_wdog, w_data_i, w_strb_i);
      if (w_wr_scratch) r_scratch <= strb_merge(r_scratch, w_data_i, w_strb_i);
      if (w_wr_hs)      r_bresp   <= w_werr ? RESP_SLVERR : RESP_OKAY;
      if (w_rd_hs)      r_rsp     <= w_rsp_d;
    end
  end

endmodule
